// File: rtl/debug_unit.sv
// debug_unit: host command decoder and pipeline state dumper.
// Decodes single-byte UART commands ('c' run, 's' step, 'r' reset) and
// streams PC, ALU result, register file and data memory back, MSB first.
// Optional macro DEBUG_UNIT_CYCLE_COUNT_EN appends a saturating 32-bit
// count of step cycles as the final dump word.
module debug_unit #(
  parameter int NB          = 32,
  parameter int NB_BYTE     = 8,
  parameter int N_REGS      = 32,
  parameter int N_MEM_WORDS = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_ready,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_halt,
  input  logic [NB-1:0]      i_mips_pc,
  input  logic [NB-1:0]      i_mips_alu_result,
  input  logic [NB-1:0]      i_mips_register_data,
  input  logic [NB-1:0]      i_mips_data_memory,
  output logic               o_step,
  output logic               o_mips_reset,
  output logic [4:0]         o_debug_register_number,
  output logic [NB-1:0]      o_debug_address
);

  // Item order: PC, ALU, registers, memory words, optional step counter.
  localparam int N_BASE_ITEMS = 2 + N_REGS + N_MEM_WORDS;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
  localparam int N_ITEMS = N_BASE_ITEMS + 1;
`else
  localparam int N_ITEMS = N_BASE_ITEMS;
`endif
  localparam int IW = $clog2(N_ITEMS + 1);
  localparam logic [IW-1:0] REG_FIRST = IW'(2);
  localparam logic [IW-1:0] MEM_FIRST = IW'(2 + N_REGS);
  localparam logic [IW-1:0] MEM_END   = IW'(N_BASE_ITEMS);
  localparam logic [IW-1:0] LAST_ITEM = IW'(N_ITEMS - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(NB / NB_BYTE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RUN, S_STEP, S_PRST, S_ACK, S_ACK_HOLD,
    S_SETUP, S_LATCH, S_SEND, S_HOLD, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      item_q, item_d;
  logic [1:0]         byte_q, byte_d;
  logic [NB-1:0]      shift_q, shift_d;
  logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic [4:0]         reg_num_q, reg_num_d;
  logic [NB-1:0]      addr_q, addr_d;
  logic [NB-1:0]      cycle_cnt_q;
  logic               step_c;
  logic               mips_rst_c;
  logic [IW-1:0]      mem_off;

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
  // Saturating count of issued step cycles; 'r' restarts it.
  always_ff @(posedge i_clk) begin
    if (i_reset || state_q == S_PRST) begin
      cycle_cnt_q <= '0;
    end else if (step_c && cycle_cnt_q != '1) begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
    end
  end
`else
  assign cycle_cnt_q = '0;
`endif

  // State and datapath registers; reset aborts any transfer in progress.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      item_q     <= '0;
      byte_q     <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      reg_num_q  <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      item_q     <= item_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      reg_num_q  <= reg_num_d;
      addr_q     <= addr_d;
    end
  end

  // Next-state, command decode, dump sequencing and step/reset strobes.
  always_comb begin
    state_d    = state_q;
    item_d     = item_q;
    byte_d     = byte_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    reg_num_d  = reg_num_q;
    addr_d     = addr_q;
    step_c     = 1'b0;
    mips_rst_c = 1'b0;
    mem_off    = item_q - MEM_FIRST;
    case (state_q)
      S_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            8'h63:   state_d = S_RUN;
            8'h73:   state_d = S_STEP;
            8'h72:   state_d = S_PRST;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        if (i_halt) begin
          state_d = S_SETUP;
          item_d  = '0;
          byte_d  = '0;
        end else begin
          step_c = 1'b1;
        end
      end
      S_STEP: begin
        step_c  = ~i_halt;
        state_d = S_SETUP;
        item_d  = '0;
        byte_d  = '0;
      end
      S_PRST: begin
        mips_rst_c = 1'b1;
        state_d    = S_ACK;
      end
      S_ACK: begin
        if (i_tx_ready) begin
          tx_data_d  = NB_BYTE'(8'h06);
          tx_start_d = 1'b1;
          state_d    = S_ACK_HOLD;
        end
      end
      S_ACK_HOLD: state_d = S_IDLE;
      S_SETUP: begin
        // Point the pipeline's debug ports at the item; held until next SETUP.
        if (item_q >= REG_FIRST && item_q < MEM_FIRST) begin
          reg_num_d = 5'(item_q - REG_FIRST);
        end else if (item_q >= MEM_FIRST && item_q < MEM_END) begin
          addr_d = NB'(mem_off) << 2;
        end
        state_d = S_LATCH;
      end
      S_LATCH: begin
        if (item_q == '0) begin
          shift_d = i_mips_pc;
        end else if (item_q == IW'(1)) begin
          shift_d = i_mips_alu_result;
        end else if (item_q < MEM_FIRST) begin
          shift_d = i_mips_register_data;
        end else if (item_q < MEM_END) begin
          shift_d = i_mips_data_memory;
        end else begin
          shift_d = cycle_cnt_q;
        end
        state_d = S_SEND;
      end
      S_SEND: begin
        if (i_tx_ready) begin
          tx_data_d  = shift_q[NB-1 -: NB_BYTE];
          tx_start_d = 1'b1;
          shift_d    = shift_q << NB_BYTE;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        // Ignores i_tx_ready for a cycle so the UART can raise busy.
        if (byte_q == LAST_BYTE) begin
          byte_d = '0;
          if (item_q == LAST_ITEM) begin
            state_d = S_DONE;
          end else begin
            item_d  = item_q + 1'b1;
            state_d = S_SETUP;
          end
        end else begin
          byte_d  = byte_q + 1'b1;
          state_d = S_SEND;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_tx_data               = tx_data_q;
  assign o_tx_start              = tx_start_q;
  assign o_step                  = step_c;
  assign o_mips_reset            = mips_rst_c;
  assign o_debug_register_number = reg_num_q;
  assign o_debug_address         = addr_q;

endmodule
